// File: rtl/dvfs_pkg.sv
// Shared DVFS types and reset constants. The DVFS controller and the
// transition sequencer both import this so they agree on the power-on
// operating point.
package dvfs_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LOW    = 2'b01,
    MODE_MEDIUM = 2'b10,
    MODE_HIGH   = 2'b11
  } perf_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_V_REQ    = 3'd1,
    ST_V_REL    = 3'd2,
    ST_V_SETTLE = 3'd3,
    ST_F_GATE   = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    DIR_NOP   = 2'd0,
    DIR_UP    = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_FONLY = 2'd3
  } dir_e;

  // Phase of the regulator four-phase handshake.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_REL  = 2'd2
  } hs_phase_e;

  localparam perf_mode_e RST_MODE = MODE_LOW;
  localparam logic [2:0] RST_DIV  = 3'd4;

  // Counter width large enough to hold the largest of three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dvfs_vreg_handshake.sv
// Four-phase handshake with the voltage regulator.
// start (one cycle, only honoured in HS_IDLE) raises vreg_req with a new
// target level. acked pulses when vreg_ack is sampled high, after which
// vreg_req drops; done pulses when vreg_ack is then sampled low and the
// level is recorded as last_level. timeout pulses if either ack edge fails
// to arrive within ACK_TIMEOUT cycles; the level falls back to last_level.
module dvfs_vreg_handshake
  import dvfs_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024,
  parameter int CW          = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] start_level,
  input  logic       vreg_ack,
  output logic       vreg_req,
  output logic [1:0] vreg_level,
  output logic       acked,
  output logic       done,
  output logic       timeout,
  output hs_phase_e  dbg_phase
);

  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  hs_phase_e     phase_q, phase_d;
  logic [CW-1:0] ack_cnt;
  logic [1:0]    last_level;
  logic          expired;

  assign expired   = (ack_cnt == ACK_LAST);
  assign dbg_phase = phase_q;

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) phase_q <= HS_IDLE;
    else     phase_q <= phase_d;
  end

  // Next phase and the event pulses seen by the sequencer FSM.
  always_comb begin
    phase_d = phase_q;
    acked   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (phase_q)
      HS_IDLE: if (start) phase_d = HS_REQ;
      HS_REQ: begin
        if (vreg_ack) begin
          acked   = 1'b1;
          phase_d = HS_REL;
        end else if (expired) begin
          timeout = 1'b1;
          phase_d = HS_IDLE;
        end
      end
      HS_REL: begin
        if (!vreg_ack) begin
          done    = 1'b1;
          phase_d = HS_IDLE;
        end else if (expired) begin
          timeout = 1'b1;
          phase_d = HS_IDLE;
        end
      end
      default: phase_d = HS_IDLE;
    endcase
  end

  // Regulator outputs, saturating ack counter and last confirmed level.
  always_ff @(posedge clk) begin
    if (rst) begin
      vreg_req   <= 1'b0;
      vreg_level <= RST_MODE;
      last_level <= RST_MODE;
      ack_cnt    <= '0;
    end else if (phase_q == HS_IDLE && start) begin
      vreg_req   <= 1'b1;
      vreg_level <= start_level;
      ack_cnt    <= '0;
    end else if (acked) begin
      vreg_req <= 1'b0;
      ack_cnt  <= '0;
    end else if (done) begin
      last_level <= vreg_level;
      ack_cnt    <= '0;
    end else if (timeout) begin
      vreg_req   <= 1'b0;
      vreg_level <= last_level;
      ack_cnt    <= '0;
    end else if (phase_q != HS_IDLE && ack_cnt != CNT_MAX) begin
      ack_cnt <= ack_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Applies a requested performance point safely: voltage before frequency
// when speeding up, frequency before voltage when slowing down. The
// divided clock is gated low across every ratio change.
// Request handshake: a request transfers on a clock edge where
// req_valid && req_ready; req_ready is high only in IDLE, and a requester
// must hold req_valid (and its payload) until that edge.
module dvfs_transition_sequencer
  import dvfs_pkg::*;
#(
  parameter int SETTLE_CYCLES      = 64,
  parameter int FREQ_SWITCH_CYCLES = 4,
  parameter int ACK_TIMEOUT        = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_mode,
  input  logic [2:0] req_div,
  output logic       vreg_req,
  output logic [1:0] vreg_level,
  input  logic       vreg_ack,
  output logic [2:0] div_ratio,
  output logic       clk_gate_en,
  output logic [1:0] cur_mode,
  output logic       busy,
  output logic       err_timeout,
  output seq_state_e dbg_state,
  output hs_phase_e  dbg_hs_phase
);

  localparam int            CW          = cnt_width(SETTLE_CYCLES, ACK_TIMEOUT, FREQ_SWITCH_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] FSW_LAST    = CW'(FREQ_SWITCH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  seq_state_e    state_q, state_d;
  dir_e          dir_d, dir_q;
  logic [1:0]    tgt_mode;
  logic [2:0]    tgt_div;
  logic [2:0]    req_div_eff;
  logic [CW-1:0] seq_cnt;
  logic          accept;
  logic          complete;
  logic          hs_start;
  logic [1:0]    hs_level;
  logic          hs_acked, hs_done, hs_timeout;

  // A zero ratio is meaningless to the divider; treat it as divide-by-1.
  assign req_div_eff = (req_div == 3'd0) ? 3'd1 : req_div;
  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

  // Direction of the incoming request relative to the applied point.
  always_comb begin
    dir_d = DIR_NOP;
    if (req_mode > cur_mode)          dir_d = DIR_UP;
    else if (req_mode < cur_mode)     dir_d = DIR_DOWN;
    else if (req_div_eff != div_ratio) dir_d = DIR_FONLY;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake start and completion detection.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    hs_start = 1'b0;
    hs_level = tgt_mode;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          case (dir_d)
            DIR_UP: begin
              state_d  = ST_V_REQ;
              hs_start = 1'b1;
              hs_level = req_mode;
            end
            DIR_DOWN, DIR_FONLY: state_d = ST_F_GATE;
            default:             state_d = ST_IDLE;
          endcase
        end
      end
      ST_V_REQ: begin
        if (hs_timeout)    state_d = ST_IDLE;
        else if (hs_acked) state_d = ST_V_REL;
      end
      ST_V_REL: begin
        if (hs_timeout) begin
          state_d = ST_IDLE;
        end else if (hs_done) begin
          if (dir_q == DIR_UP) begin
            state_d = ST_V_SETTLE;
          end else begin
            state_d  = ST_IDLE;
            complete = 1'b1;
          end
        end
      end
      ST_V_SETTLE: if (seq_cnt == SETTLE_LAST) state_d = ST_F_GATE;
      ST_F_GATE: begin
        if (seq_cnt == FSW_LAST) begin
          if (dir_q == DIR_DOWN) begin
            state_d  = ST_V_REQ;
            hs_start = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            complete = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Target latch, phase counter, divider, clock gate, applied mode, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_mode    <= RST_MODE;
      tgt_div     <= RST_DIV;
      dir_q       <= DIR_NOP;
      seq_cnt     <= '0;
      div_ratio   <= RST_DIV;
      clk_gate_en <= 1'b1;
      cur_mode    <= RST_MODE;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        tgt_mode <= req_mode;
        tgt_div  <= req_div_eff;
        dir_q    <= dir_d;
      end
      if (state_d != state_q)    seq_cnt <= '0;
      else if (seq_cnt != CNT_MAX) seq_cnt <= seq_cnt + 1'b1;
      // Gate is low exactly while in F_GATE, so it is already low one
      // cycle before the ratio moves and rises the cycle after exit.
      clk_gate_en <= (state_d != ST_F_GATE);
      if (state_q == ST_F_GATE && seq_cnt == '0) div_ratio <= tgt_div;
      if (complete)   cur_mode    <= tgt_mode;
      if (hs_timeout) err_timeout <= 1'b1;
    end
  end

  dvfs_vreg_handshake #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CW          (CW)
  ) u_vreg_hs (
    .clk         (clk),
    .rst         (rst),
    .start       (hs_start),
    .start_level (hs_level),
    .vreg_ack    (vreg_ack),
    .vreg_req    (vreg_req),
    .vreg_level  (vreg_level),
    .acked       (hs_acked),
    .done        (hs_done),
    .timeout     (hs_timeout),
    .dbg_phase   (dbg_hs_phase)
  );

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Bench for dvfs_transition_sequencer: a behavioural regulator answers the
// four-phase handshake, a watcher records per-transaction timing, and the
// final {err_timeout, cur_mode, div_ratio} of each transaction is checked
// against an expected queue.
module tb_dvfs_transition_sequencer;
  import dvfs_pkg::*;

  localparam int SETTLE   = 64;
  localparam int FSW      = 4;
  localparam int ACK_TO   = 1024;
  localparam int ACK_RISE = 3;
  localparam int ACK_FALL = 2;
  localparam logic [11:0] RST_VEC = {2'b01, 3'd4, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic [1:0] req_mode  = 2'b00;
  logic [2:0] req_div   = 3'd0;
  logic       vreg_ack  = 1'b0;
  logic       req_ready, vreg_req, clk_gate_en, busy, err_timeout;
  logic [1:0] vreg_level, cur_mode;
  logic [2:0] div_ratio;
  seq_state_e dbg_state;
  hs_phase_e  dbg_hs_phase;

  dvfs_transition_sequencer #(
    .SETTLE_CYCLES      (SETTLE),
    .FREQ_SWITCH_CYCLES (FSW),
    .ACK_TIMEOUT        (ACK_TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_div      (req_div),
    .vreg_req     (vreg_req),
    .vreg_level   (vreg_level),
    .vreg_ack     (vreg_ack),
    .div_ratio    (div_ratio),
    .clk_gate_en  (clk_gate_en),
    .cur_mode     (cur_mode),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .dbg_state    (dbg_state),
    .dbg_hs_phase (dbg_hs_phase)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  logic [5:0] exp_v, got_v;
  logic [11:0] out_v;
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- regulator model ----------------
  bit reg_auto = 1'b1;
  int reg_cnt  = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reg_auto || rst) begin
        vreg_ack = 1'b0;
        reg_cnt  = 0;
      end else if (vreg_req && !vreg_ack) begin
        reg_cnt++;
        if (reg_cnt >= ACK_RISE) begin vreg_ack = 1'b1; reg_cnt = 0; end
      end else if (!vreg_req && vreg_ack) begin
        reg_cnt++;
        if (reg_cnt >= ACK_FALL) begin vreg_ack = 1'b0; reg_cnt = 0; end
      end else begin
        reg_cnt = 0;
      end
    end
  end

  // ---------------- driver / watcher ----------------
  task automatic drive_req(input logic [1:0] mode, input logic [2:0] div);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_mode  = mode;
    req_div   = div;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  int w_gate_low, w_gate_first, w_div_first, w_vreq_first, w_last_vrel, w_vreq_cycles;
  logic [1:0] w_level_at_div;
  bit w_settle_seen, w_timed_out;

  // Follows one transaction cycle by cycle (sampled on negedge) until busy falls.
  task automatic watch_txn(input int budget);
    logic [2:0] div0;
    bit fin;
    div0 = div_ratio;
    w_gate_low = 0; w_gate_first = -1; w_div_first = -1; w_vreq_first = -1;
    w_last_vrel = -1; w_vreq_cycles = 0; w_level_at_div = 2'b00;
    w_settle_seen = 1'b0; w_timed_out = 1'b0; fin = 1'b0;
    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge clk);
      if (!clk_gate_en) begin
        w_gate_low++;
        if (w_gate_first < 0) w_gate_first = c;
      end
      if (div_ratio != div0 && w_div_first < 0) begin
        w_div_first    = c;
        w_level_at_div = vreg_level;
      end
      if (vreg_req && w_vreq_first < 0) w_vreq_first = c;
      if (dbg_state == ST_V_REL)    w_last_vrel = c;
      if (dbg_state == ST_V_REQ)    w_vreq_cycles++;
      if (dbg_state == ST_V_SETTLE) w_settle_seen = 1'b1;
      if (!busy) fin = 1'b1;
    end
    if (!fin) w_timed_out = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_v = {cur_mode, div_ratio, vreg_level, clk_gate_en, req_ready, vreg_req, busy, err_timeout};
      n_checks++;
      if (out_v !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %b expected %b", i, out_v, RST_VEC);
      end
    end
  endtask

  task automatic test_up();
    drive_req(2'b11, 3'd1);
    exp_q.push_back({1'b0, 2'b11, 3'd1});
    watch_txn(400);
    n_checks++;
    if (w_timed_out) begin n_fail++; $display("FAIL up_done: busy still high after 400 cycles"); end
    n_checks++;
    if (w_div_first < 0 || w_level_at_div !== 2'b11) begin
      n_fail++;
      $display("FAIL up_volt_first: level at div change %b expected 11 (div change cycle %0d)", w_level_at_div, w_div_first);
    end
    n_checks++;
    if (w_div_first - w_last_vrel !== SETTLE + 2) begin
      n_fail++;
      $display("FAIL up_settle_gap: got %0d expected %0d", w_div_first - w_last_vrel, SETTLE + 2);
    end
    n_checks++;
    if (w_gate_low !== FSW) begin n_fail++; $display("FAIL up_gate_len: got %0d expected %0d", w_gate_low, FSW); end
    n_checks++;
    if (!w_settle_seen) begin n_fail++; $display("FAIL up_settle_seen: got 0 expected 1"); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL up_ready: got %b expected 1", req_ready); end
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (got_v !== exp_v) begin n_fail++; $display("FAIL up_result: got %b expected %b", got_v, exp_v); end
  endtask

  task automatic test_down();
    drive_req(2'b00, 3'd7);
    exp_q.push_back({1'b0, 2'b00, 3'd7});
    watch_txn(200);
    n_checks++;
    if (w_timed_out) begin n_fail++; $display("FAIL down_done: busy still high after 200 cycles"); end
    n_checks++;
    if (w_gate_first < 0 || w_vreq_first < 0 || w_gate_first >= w_vreq_first) begin
      n_fail++;
      $display("FAIL down_gate_first: gate low at %0d vreg_req at %0d", w_gate_first, w_vreq_first);
    end
    n_checks++;
    if (w_div_first < 0 || w_div_first >= w_vreq_first) begin
      n_fail++;
      $display("FAIL down_div_first: div change at %0d vreg_req at %0d", w_div_first, w_vreq_first);
    end
    n_checks++;
    if (w_settle_seen) begin n_fail++; $display("FAIL down_no_settle: got 1 expected 0"); end
    n_checks++;
    if (vreg_level !== 2'b00) begin n_fail++; $display("FAIL down_level: got %b expected 00", vreg_level); end
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (got_v !== exp_v) begin n_fail++; $display("FAIL down_result: got %b expected %b", got_v, exp_v); end
  endtask

  task automatic test_fonly();
    bit busy_seen;
    // Move to MEDIUM / div 2 first.
    drive_req(2'b10, 3'd2);
    exp_q.push_back({1'b0, 2'b10, 3'd2});
    watch_txn(400);
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (w_timed_out || got_v !== exp_v) begin n_fail++; $display("FAIL fonly_setup: got %b expected %b", got_v, exp_v); end
    // Same mode, new ratio.
    drive_req(2'b10, 3'd4);
    exp_q.push_back({1'b0, 2'b10, 3'd4});
    watch_txn(50);
    n_checks++;
    if (w_vreq_first >= 0) begin n_fail++; $display("FAIL fonly_no_vreq: vreg_req seen at cycle %0d expected never", w_vreq_first); end
    n_checks++;
    if (w_gate_low !== FSW) begin n_fail++; $display("FAIL fonly_gate_len: got %0d expected %0d", w_gate_low, FSW); end
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (w_timed_out || got_v !== exp_v) begin n_fail++; $display("FAIL fonly_result: got %b expected %b", got_v, exp_v); end
    // Identical request: nothing happens.
    drive_req(2'b10, 3'd4);
    busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || !req_ready || !clk_gate_en) busy_seen = 1'b1;
    end
    n_checks++;
    if (busy_seen) begin n_fail++; $display("FAIL nop_idle: got busy/gate activity expected none"); end
  endtask

  task automatic test_timeout();
    reg_auto = 1'b0;
    drive_req(2'b11, 3'd1);
    exp_q.push_back({1'b1, 2'b10, 3'd4});
    watch_txn(ACK_TO + 100);
    n_checks++;
    if (w_timed_out) begin n_fail++; $display("FAIL to_done: busy still high after %0d cycles", ACK_TO + 100); end
    n_checks++;
    if (w_vreq_cycles !== ACK_TO) begin n_fail++; $display("FAIL to_wait_len: got %0d expected %0d", w_vreq_cycles, ACK_TO); end
    n_checks++;
    if (vreg_req !== 1'b0) begin n_fail++; $display("FAIL to_vreq: got %b expected 0", vreg_req); end
    n_checks++;
    if (vreg_level !== 2'b10) begin n_fail++; $display("FAIL to_level: got %b expected 10", vreg_level); end
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (got_v !== exp_v) begin n_fail++; $display("FAIL to_result: got %b expected %b", got_v, exp_v); end
    // Sticky error survives a later successful transition.
    reg_auto = 1'b1;
    drive_req(2'b11, 3'd1);
    exp_q.push_back({1'b1, 2'b11, 3'd1});
    watch_txn(400);
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (w_timed_out || got_v !== exp_v) begin n_fail++; $display("FAIL to_sticky: got %b expected %b", got_v, exp_v); end
  endtask

  task automatic test_reset_mid();
    int  fg;
    bit  found;
    drive_req(2'b01, 3'd6);
    fg = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (dbg_state == ST_F_GATE) fg++;
      if (fg == 2) found = 1'b1;
    end
    n_checks++;
    if (!found || div_ratio !== 3'd6) begin
      n_fail++;
      $display("FAIL mid_fgate2: found=%0d div %0d expected 6", found, div_ratio);
    end
    rst = 1'b1;
    @(negedge clk);
    out_v = {cur_mode, div_ratio, vreg_level, clk_gate_en, req_ready, vreg_req, busy, err_timeout};
    n_checks++;
    if (out_v !== RST_VEC) begin n_fail++; $display("FAIL mid_reset_state: got %b expected %b", out_v, RST_VEC); end
    rst       = 1'b0;
    req_valid = 1'b1;
    req_mode  = 2'b11;
    req_div   = 3'd2;
    exp_q.push_back({1'b0, 2'b11, 3'd2});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || dbg_state !== ST_V_REQ) begin
      n_fail++;
      $display("FAIL mid_accept: busy %b state %0d expected busy 1 state %0d", busy, dbg_state, ST_V_REQ);
    end
    watch_txn(400);
    exp_v = exp_q.pop_front();
    got_v = {err_timeout, cur_mode, div_ratio};
    n_checks++;
    if (w_timed_out || got_v !== exp_v) begin n_fail++; $display("FAIL mid_result: got %b expected %b", got_v, exp_v); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_up();
    test_down();
    test_fonly();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
